// File: rtl/fifo_watermark_monitor_pkg.sv
// Shared constants for the switch FIFO monitor and the control FSM.
// Holds the FIFO index map and the default counter width and depth.
package fifo_mon_pkg;

  localparam int NUM_FIFOS = 5;

  localparam int FIFO_MAIN = 0;
  localparam int FIFO_VC0  = 1;
  localparam int FIFO_VC1  = 2;
  localparam int FIFO_D0   = 3;
  localparam int FIFO_D1   = 4;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_CW    = 5;

endpackage

// File: rtl/fifo_watermark_monitor_if.sv
// Bundle of threshold config, push/pop strobes and status outputs of the monitor.
interface fifo_watermark_monitor_if
  import fifo_mon_pkg::*;
#(
  parameter int CW = DEF_CW
);

  logic                    cfg_load;
  logic [NUM_FIFOS*CW-1:0] lo_th;
  logic [NUM_FIFOS*CW-1:0] hi_th;
  logic [NUM_FIFOS-1:0]    push;
  logic [NUM_FIFOS-1:0]    pop;
  logic [NUM_FIFOS*CW-1:0] count;
  logic [NUM_FIFOS-1:0]    empties;
  logic [NUM_FIFOS-1:0]    errors;
  logic [NUM_FIFOS-1:0]    almost_full;
  logic [NUM_FIFOS-1:0]    almost_empty;

  modport master (
    output cfg_load, lo_th, hi_th, push, pop,
    input  count, empties, errors, almost_full, almost_empty
  );

  modport slave (
    input  cfg_load, lo_th, hi_th, push, pop,
    output count, empties, errors, almost_full, almost_empty
  );

endinterface

// File: rtl/fifo_watermark_monitor_level_track.sv
// One FIFO's occupancy counter, sticky error bit, threshold registers and
// registered watermark flags.
module fifo_level_track
  import fifo_mon_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_load,
  input  logic [CW-1:0] lo_th,
  input  logic [CW-1:0] hi_th,
  input  logic          push,
  input  logic          pop,
  output logic [CW-1:0] count,
  output logic          not_empty,
  output logic          error,
  output logic          almost_full,
  output logic          almost_empty
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] lo_r;
  logic [CW-1:0] hi_r;
  logic [CW-1:0] count_nxt;
  logic          err_set;

  always_comb begin
    count_nxt = count;
    err_set   = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (count < DEPTH_C) count_nxt = count + CW'(1);
        else                 err_set   = 1'b1;
      end
      2'b01: begin
        if (count != '0) count_nxt = count - CW'(1);
        else             err_set   = 1'b1;
      end
      2'b11: begin
        // Pop against an empty FIFO underflows, but the paired push still lands.
        if (count == '0) begin
          count_nxt = CW'(1);
          err_set   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lo_r         <= '0;
      hi_r         <= '0;
      count        <= '0;
      not_empty    <= 1'b0;
      error        <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (cfg_load) begin
        lo_r <= lo_th;
        hi_r <= hi_th;
      end
      // Flags use the thresholds in force before any load on this same edge.
      count        <= count_nxt;
      not_empty    <= (count_nxt != '0);
      error        <= error | err_set;
      almost_full  <= (hi_r != '0) && (count_nxt >= hi_r);
      almost_empty <= (count_nxt <= lo_r);
    end
  end

endmodule

// File: rtl/fifo_watermark_monitor.sv
// Occupancy and watermark monitor for the five switch FIFOs; packs the
// per-FIFO trackers onto the shared monitor interface.
module fifo_watermark_monitor
  import fifo_mon_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = DEF_CW
) (
  input logic                     clk,
  input logic                     reset,
  fifo_watermark_monitor_if.slave bus
);

  logic [NUM_FIFOS*CW-1:0] count_flat;
  logic [NUM_FIFOS-1:0]    not_empty;
  logic [NUM_FIFOS-1:0]    error;
  logic [NUM_FIFOS-1:0]    almost_full;
  logic [NUM_FIFOS-1:0]    almost_empty;

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_track
    fifo_level_track #(
      .DEPTH (DEPTH),
      .CW    (CW)
    ) u_track (
      .clk          (clk),
      .reset        (reset),
      .cfg_load     (bus.cfg_load),
      .lo_th        (bus.lo_th[CW*i +: CW]),
      .hi_th        (bus.hi_th[CW*i +: CW]),
      .push         (bus.push[i]),
      .pop          (bus.pop[i]),
      .count        (count_flat[CW*i +: CW]),
      .not_empty    (not_empty[i]),
      .error        (error[i]),
      .almost_full  (almost_full[i]),
      .almost_empty (almost_empty[i])
    );
  end

  assign bus.count        = count_flat;
  assign bus.empties      = not_empty;
  assign bus.errors       = error;
  assign bus.almost_full  = almost_full;
  assign bus.almost_empty = almost_empty;

endmodule

// File: tb/tb_fifo_watermark_monitor.sv
// Directed bench for fifo_watermark_monitor: hand-computed expectations
// checked with immediate assertions after each clock edge.
module tb_fifo_watermark_monitor;

  localparam int CW = 5;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  fifo_watermark_monitor_if #(.CW(CW)) bus ();

  fifo_watermark_monitor #(
    .DEPTH (16),
    .CW    (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] cnt(input int i);
    logic [5*CW-1:0] flat;
    flat = bus.count;
    return 32'(flat[CW*i +: CW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [4:0] p, input logic [4:0] q, input int n);
    for (int k = 0; k < n; k++) begin
      bus.push = p;
      bus.pop  = q;
      tick();
    end
    bus.push = '0;
    bus.pop  = '0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    reset        = 1'b0;
    bus.cfg_load = 1'b0;
    bus.lo_th    = '0;
    bus.hi_th    = '0;
    bus.push     = '0;
    bus.pop      = '0;

    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_empties", 32'(bus.empties), 32'h00);
    checkOutput("rst_errors", 32'(bus.errors), 32'h00);
    checkOutput("rst_ae", 32'(bus.almost_empty), 32'h1f);
    checkOutput("rst_af", 32'(bus.almost_full), 32'h00);

    bus.cfg_load = 1'b1;
    bus.lo_th    = {5{5'd2}};
    bus.hi_th    = {5{5'd12}};
    tick();
    bus.cfg_load = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      applyStimulus(5'b00010, 5'b00000, 1);
      checkOutput($sformatf("vc0_ae_%0d", k), 32'(bus.almost_empty[1]), 32'(k <= 2));
      checkOutput($sformatf("vc0_af_%0d", k), 32'(bus.almost_full[1]), 32'(k >= 12));
    end
    checkOutput("vc0_count", cnt(1), 32'd13);
    checkOutput("vc0_empties", 32'(bus.empties), 32'h02);
    checkOutput("vc0_ae_all", 32'(bus.almost_empty), 32'h1d);

    applyStimulus(5'b00001, 5'b00000, 16);
    checkOutput("main_full_count", cnt(0), 32'd16);
    checkOutput("main_full_err", 32'(bus.errors), 32'h00);
    checkOutput("main_full_af", 32'(bus.almost_full), 32'h03);
    applyStimulus(5'b00001, 5'b00000, 1);
    checkOutput("main_ovf_count", cnt(0), 32'd16);
    checkOutput("main_ovf_err", 32'(bus.errors), 32'h01);
    applyStimulus(5'b00000, 5'b00000, 10);
    checkOutput("main_sticky_err", 32'(bus.errors), 32'h01);
    checkOutput("main_sticky_count", cnt(0), 32'd16);

    applyStimulus(5'b10000, 5'b10000, 1);
    checkOutput("d1_pp_count", cnt(4), 32'd1);
    checkOutput("d1_pp_err", 32'(bus.errors), 32'h11);
    checkOutput("d1_pp_empties", 32'(bus.empties), 32'h13);

    applyStimulus(5'b00100, 5'b00000, 16);
    applyStimulus(5'b00100, 5'b00100, 1);
    checkOutput("vc1_pp_count", cnt(2), 32'd16);
    checkOutput("vc1_pp_err", 32'(bus.errors), 32'h11);

    applyStimulus(5'b00000, 5'b01000, 1);
    checkOutput("d0_unf_count", cnt(3), 32'd0);
    applyStimulus(5'b01000, 5'b00000, 7);
    checkOutput("d0_count", cnt(3), 32'd7);
    checkOutput("d0_err", 32'(bus.errors), 32'h19);

    reset    = 1'b0;
    bus.push = 5'b01000;
    tick();
    bus.push = '0;
    reset    = 1'b1;
    checkOutput("mid_rst_count", 32'(bus.count), 32'd0);
    checkOutput("mid_rst_err", 32'(bus.errors), 32'h00);
    checkOutput("mid_rst_empties", 32'(bus.empties), 32'h00);
    checkOutput("mid_rst_ae", 32'(bus.almost_empty), 32'h1f);
    checkOutput("mid_rst_af", 32'(bus.almost_full), 32'h00);

    applyStimulus(5'b01000, 5'b00000, 1);
    checkOutput("post_rst_count", cnt(3), 32'd1);
    checkOutput("post_rst_ae", 32'(bus.almost_empty), 32'h17);
    checkOutput("post_rst_af", 32'(bus.almost_full), 32'h00);

    // New thresholds lo=3 >= hi=1 only take effect on the edge after the load.
    bus.cfg_load = 1'b1;
    bus.lo_th    = {5{5'd3}};
    bus.hi_th    = {5{5'd1}};
    tick();
    bus.cfg_load = 1'b0;
    checkOutput("load_edge_ae", 32'(bus.almost_empty), 32'h17);
    checkOutput("load_edge_af", 32'(bus.almost_full), 32'h00);
    tick();
    checkOutput("overlap_ae", 32'(bus.almost_empty), 32'h1f);
    checkOutput("overlap_af", 32'(bus.almost_full), 32'h08);
    checkOutput("overlap_err", 32'(bus.errors), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_watermark_monitor.md
# fifo_watermark_monitor

Occupancy and watermark monitor for the five switch FIFOs (main, VC0, VC1, D0, D1). It is the counterpart of the control FSM: it consumes the low/high thresholds the FSM latches during INIT and returns the per-FIFO `empties` and `errors` vectors that drive the FSM's IDLE→ACTIVE and ACTIVE→ERROR transitions. It also raises almost-full and almost-empty flags for the flow-control logic.

## Interface
- `DEPTH`, default 16: entries per FIFO. Maximum legal value is 31.
- `CW`, default 5: counter and threshold width. Must satisfy DEPTH < 2**CW.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low.
- `cfg_load`  in  1  latch thresholds this cycle.
- `lo_th`  in  5*CW  low thresholds, packed, [CW*i +: CW] for FIFO i.
- `hi_th`  in  5*CW  high thresholds, same packing.
- `push`  in  5  write strobe per FIFO.
- `pop`  in  5  read strobe per FIFO.
- `count`  out  5*CW  current occupancy, packed.
- `empties`  out  5  bit i = 0 when FIFO i is empty, 1 when it holds data. `empties == 0` means all FIFOs are empty.
- `errors`  out  5  sticky overflow/underflow per FIFO.
- `almost_full`  out  5  count ≥ high threshold.
- `almost_empty`  out  5  count ≤ low threshold.
- FIFO index map: 0 = main, 1 = VC0, 2 = VC1, 3 = D0, 4 = D1.

## Operation
- Thresholds:
  - Internal `lo_r` and `hi_r` registers load from `lo_th` and `hi_th` on a clock edge where `cfg_load`=1.
  - They hold otherwise.
  - Reset value is 0.
- Per-FIFO occupancy update, for each i:
  - push only, count < DEPTH: count+1.
  - push only, count == DEPTH: overflow. Count holds, `errors[i]` is set.
  - pop only, count > 0: count−1.
  - pop only, count == 0: underflow. Count holds at 0, `errors[i]` is set.
  - push and pop, count > 0: count unchanged, no error. This includes count == DEPTH.
  - push and pop, count == 0: the pop is an underflow. `errors[i]` is set, the push is applied, count becomes 1.
  - neither: hold.
- `errors` bits are sticky. They clear only on reset; `cfg_load` does not clear them. This matches the FSM, which leaves ERROR only through reset.
- Flags, computed from the post-update count:
  - `empties[i]` = (count ≠ 0).
  - `almost_empty[i]` = (count ≤ lo_r[i]).
  - `almost_full[i]` = (hi_r[i] ≠ 0) && (count ≥ hi_r[i]). A high threshold of 0 disables the flag.
- Threshold edge cases:
  - If lo_r ≥ hi_r, both flags may be asserted together. This is legal; no error is raised.
  - Thresholds above DEPTH are not clipped. Comparisons are plain unsigned CW-bit compares.
- No saturation or wrap-around: a counter never leaves the range 0..DEPTH.

## Timing
- All outputs are registered. Count and every flag reflect the push/pop events sampled at edge N, visible after edge N.
- Event-to-flag latency is one cycle, the same as count.
- A threshold change via `cfg_load` at edge N affects the flags computed at edge N+1 onward. The flags at edge N use the old thresholds.
- Reset (`reset`=0 at an edge):
  - count = 0, `empties` = 0, `errors` = 0, `almost_full` = 0.
  - `almost_empty` = 5'b11111, since 0 ≤ 0.
  - `lo_r` = `hi_r` = 0.
  - Reset takes priority over push, pop and `cfg_load` in the same cycle.
- Reset applied mid-traffic discards all occupancy. The first strobes after reset release are counted from 0.
- `push` and `pop` are single-cycle strobes. Every cycle a strobe is high is counted as one event; there is no handshake back.

## Structure
- Shared package `fifo_mon_pkg` holds:
  - FIFO index constants: `FIFO_MAIN`, `FIFO_VC0`, `FIFO_VC1`, `FIFO_D0`, `FIFO_D1`.
  - `NUM_FIFOS` = 5.
  - Default `CW`/`DEPTH`. The control FSM uses the same constants.
- Sub-module `fifo_level_track`:
  - Contains one counter, the sticky error bit, the threshold registers and the flag logic.
  - Instantiated five times via generate.
- The top level only does packing and unpacking, roughly 60 lines.

## Test plan
- Reset then idle: all counts are 0, `empties`=0, `errors`=0, `almost_empty`=11111, `almost_full`=00000.
- Load thresholds lo=2, hi=12 (DEPTH=16), then push FIFO 1 thirteen times:
  - count[1]=13, `empties`=00010.
  - `almost_empty[1]` drops after the 3rd push.
  - `almost_full[1]` rises after the 12th push.
- Fill FIFO 0 to 16, then push once more: count stays 16, `errors`=00001, and the bit persists through 10 idle cycles.
- Pop FIFO 4 at empty with a simultaneous push: count[4]=1, `errors[4]`=1, `empties[4]`=1.
- FIFO 2 at count 16 with push and pop in the same cycle: count stays 16, `errors[2]` stays 0.
- With FIFO 3 at count 7 and `errors[3]`=1, assert `reset`=0 together with `push[3]`: all counts are 0, `errors`=0, and the push is ignored.
